// File: rtl/immediate_sel_if.sv
// Immediate-select bus: the select code enum plus the interface that bundles
// the candidate immediates, qualifiers and the selected/registered results.
package immediate_sel_pkg;
  typedef enum logic [2:0] {
    IMM_TYPE_I = 3'd0,
    IMM_TYPE_S = 3'd1,
    IMM_TYPE_B = 3'd2,
    IMM_TYPE_U = 3'd3,
    IMM_TYPE_J = 3'd4,
    IMM_TYPE_R = 3'd5
  } imm_sel_e;
endpackage

interface immediate_sel_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  import immediate_sel_pkg::*;

  imm_sel_e                  ImmSel_i;
  logic                      sel_valid_i;
  logic                      clr_i;
  logic [DATA_WIDTH-1:0]     imm_i_i;
  logic [DATA_WIDTH-1:0]     imm_s_i;
  logic [DATA_WIDTH-1:0]     imm_b_i;
  logic [DATA_WIDTH-1:0]     imm_u_i;
  logic [DATA_WIDTH-1:0]     imm_j_i;
  logic [DATA_WIDTH-1:0]     ImmSel_o;
  logic [DATA_WIDTH-1:0]     ImmSel_q_o;
  logic                      illegal_o;
  logic [6*CNT_WIDTH-1:0]    stats_o;

  // Control unit / immediate generator side
  modport master (
    output ImmSel_i, sel_valid_i, clr_i,
    output imm_i_i, imm_s_i, imm_b_i, imm_u_i, imm_j_i,
    input  ImmSel_o, ImmSel_q_o, illegal_o, stats_o
  );

  // Mux side
  modport slave (
    input  ImmSel_i, sel_valid_i, clr_i,
    input  imm_i_i, imm_s_i, imm_b_i, imm_u_i, imm_j_i,
    output ImmSel_o, ImmSel_q_o, illegal_o, stats_o
  );
endinterface

// File: rtl/immediate_sel.sv
// Decode-stage immediate mux with a registered copy, a sticky illegal-code
// flag and, when IMMSEL_STATS_EN is defined, saturating per-code usage counters.
module immediate_sel #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  immediate_sel_if.slave bus
);
  logic [2:0]            code;
  logic [DATA_WIDTH-1:0] sel;

  assign code = bus.ImmSel_i;

  // Select the immediate; non-immediate codes return the code itself so the
  // operand path sees a deterministic, recognisable value.
  always_comb begin
    sel = {{(DATA_WIDTH-3){1'b0}}, code};
    case (code)
      3'd0:    sel = bus.imm_i_i;
      3'd1:    sel = bus.imm_s_i;
      3'd2:    sel = bus.imm_b_i;
      3'd3:    sel = bus.imm_u_i;
      3'd4:    sel = bus.imm_j_i;
      default: sel = {{(DATA_WIDTH-3){1'b0}}, code};
    endcase
  end

  assign bus.ImmSel_o = sel;

  // Pipeline copy of the selection, loaded only on qualified cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bus.ImmSel_q_o <= '0;
    else if (bus.sel_valid_i) bus.ImmSel_q_o <= sel;
  end

  // Sticky illegal-code flag; clear beats a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     bus.illegal_o <= 1'b0;
    else if (bus.clr_i)                          bus.illegal_o <= 1'b0;
    else if (bus.sel_valid_i && code > 3'd5)     bus.illegal_o <= 1'b1;
  end

`ifdef IMMSEL_STATS_EN
  logic [5:0][CNT_WIDTH-1:0] cnt;

  // Saturating usage counter per legal code; illegal codes are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.clr_i) begin
      cnt <= '0;
    end else if (bus.sel_valid_i && code <= 3'd5) begin
      if (cnt[code] != {CNT_WIDTH{1'b1}}) cnt[code] <= cnt[code] + 1'b1;
    end
  end

  assign bus.stats_o = cnt;
`else
  assign bus.stats_o = '0;
`endif
endmodule

// File: tb/tb_immediate_sel.sv
// Directed bench for immediate_sel: expected values are queued when stimulus
// is applied and popped when the corresponding output is sampled.
module tb_immediate_sel;
  import immediate_sel_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [95:0] sb[$];

  always #5 clk = ~clk;

  immediate_sel_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) ifc ();

  immediate_sel #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic push(input logic [95:0] exp);
    sb.push_back(exp);
  endtask

  // Pop the oldest expectation and compare against the observed value.
  task automatic pop_check(input string tag, input logic [95:0] obs);
    logic [95:0] exp;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic v, input logic clr);
    ifc.ImmSel_i    = imm_sel_e'(c);
    ifc.sel_valid_i = v;
    ifc.clr_i       = clr;
  endtask

  initial begin
    logic [DW-1:0] imms [5];
    imms[0] = 32'h11111111; imms[1] = 32'h22222222; imms[2] = 32'h33333333;
    imms[3] = 32'h44444444; imms[4] = 32'h55555555;
    ifc.imm_i_i = imms[0]; ifc.imm_s_i = imms[1]; ifc.imm_b_i = imms[2];
    ifc.imm_u_i = imms[3]; ifc.imm_j_i = imms[4];
    drive(3'd2, 1'b0, 1'b0);

    // Reset state; the mux must still work while reset is held.
    #1;
    push(96'(imms[2])); pop_check("comb_in_reset", 96'(ifc.ImmSel_o));
    push(96'(0));       pop_check("rst_q", 96'(ifc.ImmSel_q_o));
    push(96'(0));       pop_check("rst_illegal", 96'(ifc.illegal_o));
    push(96'(0));       pop_check("rst_stats", ifc.stats_o);

    @(negedge clk); rst = 1'b0;

    // Select mux over the five immediate types.
    for (int k = 0; k < 5; k++) begin
      drive(3'(k), 1'b0, 1'b0);
      push(96'(imms[k]));
      #1 pop_check($sformatf("mux_code%0d", k), 96'(ifc.ImmSel_o));
    end

    // Default path: code value passes through zero-extended.
    drive(3'd5, 1'b0, 1'b0); push(96'(5)); #1 pop_check("mux_R", 96'(ifc.ImmSel_o));
    drive(3'd7, 1'b0, 1'b0); push(96'(7)); #1 pop_check("mux_7", 96'(ifc.ImmSel_o));
    drive(3'd6, 1'b0, 1'b0); push(96'(6)); #1 pop_check("mux_6", 96'(ifc.ImmSel_o));

    // Illegal code without valid must not set the flag or load the register.
    @(posedge clk); #1;
    push(96'(0)); pop_check("illegal_needs_valid", 96'(ifc.illegal_o));
    push(96'(0)); pop_check("q_needs_valid", 96'(ifc.ImmSel_q_o));

    // Registered capture, then hold with valid low.
    @(negedge clk); drive(3'd1, 1'b1, 1'b0); push(96'(imms[1]));
    @(posedge clk); #1 pop_check("q_capture_S", 96'(ifc.ImmSel_q_o));
    @(negedge clk); drive(3'd4, 1'b0, 1'b0); push(96'(imms[1]));
    @(posedge clk); @(posedge clk); #1 pop_check("q_hold", 96'(ifc.ImmSel_q_o));

    // Illegal flag sets, sticks across a legal code, and clears on clr.
    @(negedge clk); drive(3'd6, 1'b1, 1'b0); push(96'(1));
    @(posedge clk); #1 pop_check("illegal_set", 96'(ifc.illegal_o));
    @(negedge clk); drive(3'd0, 1'b1, 1'b0); push(96'(1)); push(96'(imms[0]));
    @(posedge clk); #1;
    pop_check("illegal_sticky", 96'(ifc.illegal_o));
    pop_check("q_capture_I", 96'(ifc.ImmSel_q_o));
    @(negedge clk); drive(3'd0, 1'b0, 1'b1); push(96'(0)); push(96'(imms[0]));
    @(posedge clk); #1;
    pop_check("illegal_clr", 96'(ifc.illegal_o));
    pop_check("clr_keeps_q", 96'(ifc.ImmSel_q_o));

    // Clear wins over a same-cycle set.
    @(negedge clk); drive(3'd7, 1'b1, 1'b1); push(96'(0)); push(96'(7));
    @(posedge clk); #1;
    pop_check("clr_beats_set", 96'(ifc.illegal_o));
    pop_check("q_capture_7", 96'(ifc.ImmSel_q_o));
    @(negedge clk); drive(3'd7, 1'b1, 1'b0); push(96'(1));
    @(posedge clk); #1 pop_check("illegal_set7", 96'(ifc.illegal_o));

    // Asynchronous reset mid-cycle, with clr also asserted.
    @(negedge clk); drive(3'd3, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    push(96'(0)); pop_check("async_rst_q", 96'(ifc.ImmSel_q_o));
    push(96'(0)); pop_check("async_rst_illegal", 96'(ifc.illegal_o));
    push(96'(imms[3])); pop_check("comb_during_rst", 96'(ifc.ImmSel_o));
    @(negedge clk); rst = 1'b0; drive(3'd0, 1'b0, 1'b0);

`ifdef IMMSEL_STATS_EN
    // 3 valid I, 2 valid J, plus one valid illegal code (counts nothing).
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(k < 3 ? 3'd0 : (k < 5 ? 3'd4 : 3'd6), 1'b1, 1'b0);
    end
    @(negedge clk); drive(3'd0, 1'b0, 1'b0);
    push({16'd0, 16'd2, 16'd0, 16'd0, 16'd0, 16'd3});
    #1 pop_check("stats_counts", ifc.stats_o);

    // Drive code U past saturation.
    drive(3'd3, 1'b1, 1'b0);
    for (int k = 0; k < 65540; k++) @(negedge clk);
    drive(3'd3, 1'b0, 1'b0);
    push(96'(16'hFFFF)); #1 pop_check("stats_saturate", 96'(ifc.stats_o[3*CW +: CW]));

    @(negedge clk); drive(3'd0, 1'b0, 1'b1);
    @(negedge clk); drive(3'd0, 1'b0, 1'b0);
    push(96'(0)); #1 pop_check("stats_clr", ifc.stats_o);
`else
    // Without the stats feature the output stays zero under valid traffic.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(3'(k), 1'b1, 1'b0);
    end
    @(negedge clk); drive(3'd0, 1'b0, 1'b0);
    push(96'(0)); #1 pop_check("stats_tied_zero", ifc.stats_o);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/immediate_sel.md
# immediate_sel

Decode-stage immediate multiplexer. It receives the five pre-decoded immediates (I, S, B, U, J) from the immediate generator and forwards the one chosen by the control unit's `ImmSel` code to the operand-B path, combinationally. A registered copy of the selection, a sticky illegal-code flag and optional per-type usage counters provide pipeline-register and debug support.

## Interface

Parameters:
- `DATA_WIDTH`, 32 (from `defines`): width of every immediate and the output.
- `CNT_WIDTH`, 16: width of each usage counter (stats build only).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ImmSel_i`  in  `imm_sel_e` (3)  select code, encoded as follows:
  - `IMM_TYPE_I`=0
  - `IMM_TYPE_S`=1
  - `IMM_TYPE_B`=2
  - `IMM_TYPE_U`=3
  - `IMM_TYPE_J`=4
  - `IMM_TYPE_R`=5
  - 6 and 7 are illegal.
- `sel_valid_i`  in  1  qualifies `ImmSel_i` for the registered, flag and counter logic.
- `clr_i`  in  1  synchronous clear of the sticky flag and counters.
- `imm_i_i`, `imm_s_i`, `imm_b_i`, `imm_u_i`, `imm_j_i`  in  `DATA_WIDTH`  candidate immediates.
- `ImmSel_o`  out  `DATA_WIDTH`  selected immediate, combinational.
- `ImmSel_q_o`  out  `DATA_WIDTH`  `ImmSel_o` registered on valid cycles.
- `illegal_o`  out  1  sticky flag for an illegal code.
- `stats_o`  out  `6*CNT_WIDTH`  usage counters, slice k = code k (codes 0..5).

## Operation

- `ImmSel_o` selects by code:
  - I → `imm_i_i`
  - S → `imm_s_i`
  - B → `imm_b_i`
  - U → `imm_u_i`
  - J → `imm_j_i`
  - any other code (R, 6, 7) → zero-extended numeric value of `ImmSel_i`. For example, `IMM_TYPE_R` yields 32'd5 and code 7 yields 32'd7.
- Immediates pass through unmodified; sign extension is done upstream.
- `ImmSel_q_o` loads `ImmSel_o` on a rising edge with `sel_valid_i`=1 and otherwise holds its value.
- `illegal_o` sets on a rising edge where `sel_valid_i`=1 and the code is 6 or 7. It stays set until `rst` or `clr_i`.
  - When `clr_i` and a set condition occur in the same cycle, `clr_i` wins.
- `ImmSel_o` does not depend on `clk`, `rst`, `sel_valid_i` or `clr_i`.

## Timing

- `ImmSel_o`: zero latency, purely combinational. It must settle within the same cycle, including while `rst` is asserted.
- `ImmSel_q_o`: 1-cycle latency.
- Reset values: `ImmSel_q_o`=0, `illegal_o`=0, all `stats_o` counters=0.
- `rst` takes effect immediately, including mid-operation, and overrides `clr_i`.
- `clr_i` affects only `illegal_o` and the counters, never `ImmSel_q_o`.

## Configuration

- `IMMSEL_STATS_EN` defined:
  - Six `CNT_WIDTH` counters, one per code 0..5.
  - The counter for the current code increments on each rising edge with `sel_valid_i`=1.
  - Counters saturate at all-ones and do not wrap.
  - Illegal codes increment no counter.
  - `clr_i` zeroes all counters.
- `IMMSEL_STATS_EN` undefined: `stats_o` is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan

- Select mux: set `imm_i_i`..`imm_j_i` to 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555. Apply codes I, S, B, U, J in turn, each followed by 1 ns of settle time → `ImmSel_o` equals the matching value in each case.
- Default path: `ImmSel_i`=`IMM_TYPE_R` → `ImmSel_o`=32'd5. Forcing code 7 → `ImmSel_o`=32'd7.
- Registered copy and flag reset: assert `rst` asynchronously mid-cycle → `ImmSel_q_o`=0 and `illegal_o`=0 immediately.
- Registered copy capture: apply S with `sel_valid_i`=1 → `ImmSel_q_o`=0x22222222 after one edge. With `sel_valid_i`=0 on later edges, it holds that value.
- Illegal flag: drive code 6 with valid → `illegal_o`=1 after the edge and stays 1 once a legal code returns. Pulse `clr_i` → `illegal_o`=0.
- Counters (stats build): 3 valid I cycles plus 2 valid J cycles → slice 0 = 3, slice 4 = 2, others 0. Preload to saturation → the counter stays at 0xFFFF.
